core_db_rx: RTL and testbench

- Receive-side counterpart of the core data-bus packetizer.
- Accepts 11-bit NoC flits, checks them, filters them by destination address, and strips the flit framing.
- Delivers the payload as an 8-bit byte stream with start-of-packet, end-of-packet and error flags.
- Sits at the clocked boundary between the NoC ejection port and the core's data bus; buffers output bytes so the core can apply backpressure.

---
 rtl/core_db_rx.sv | 206 ++++++++++++++++++++
 tb/tb_core_db_rx.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_db_rx.sv
// core_db_rx -- NoC flit receiver for the core data bus.
// Accepts 11-bit flits, checks parity and framing, drops packets addressed
// to other nodes, and delivers payload bytes through a small output FIFO so
// the core can apply backpressure.
//
// Ports:
//   CLK        clock, all state changes on the rising edge
//   RESET      synchronous active-high reset
//   in_data    flit: [10:9] kind (01 HEAD, 10 BODY), [8] even parity, [7:0] payload
//   in_valid   flit present
//   in_ready   flit accepted when in_valid && in_ready
//   out_data   payload byte
//   out_sop    first byte of a packet
//   out_eop    last byte of a packet
//   out_err    byte arrived with a parity error
//   out_valid  byte present
//   out_ready  byte consumed when out_valid && out_ready
//   err_cnt    saturating protocol/parity error count
//   pkt_cnt    saturating delivered-packet count (eop bytes pushed)
module core_db_rx #(
  parameter logic [3:0]  NODE_ADDR = 4'h0,
  parameter int unsigned DEPTH     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [10:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  err_cnt,
  output logic [7:0]  pkt_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BODY = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam logic [1:0] K_HEAD = 2'b01;
  localparam logic [1:0] K_BODY = 2'b10;

  logic [1:0]    r_state;
  logic [3:0]    r_rem;
  logic          r_first;
  logic [7:0]    r_err_cnt;
  logic [7:0]    r_pkt_cnt;

  // FIFO entry layout: {err, eop, sop, data[7:0]}
  logic [10:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic [1:0]    w_kind;
  logic          w_par_ok;
  logic [3:0]    w_dst;
  logic [3:0]    w_len;
  logic          w_full;
  logic          w_empty;
  logic          w_in_ready;
  logic          w_acc;
  logic          w_out_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_err;
  logic          w_pkt;
  logic [1:0]    w_nstate;
  logic [3:0]    w_nrem;
  logic          w_nfirst;
  logic [10:0]   w_push_data;
  logic [10:0]   w_head;

  assign w_kind   = in_data[10:9];
  assign w_par_ok = ~(^in_data[8:0]);
  assign w_dst    = in_data[7:4];
  assign w_len    = in_data[3:0];

  assign w_full  = (r_count == C_FULL);
  assign w_empty = (r_count == '0);

  // Ready is a function of registered state only (plus reset gating), so a
  // pop in the same cycle never opens a slot for a push on a full FIFO.
  assign w_in_ready  = !RESET && ((r_state != S_BODY) || !w_full);
  assign w_acc       = in_valid && w_in_ready;
  assign w_out_valid = !RESET && !w_empty;
  assign w_pop       = w_out_valid && out_ready;

  assign w_push_data = {!w_par_ok, (r_rem == 4'd1), r_first, in_data[7:0]};

  always_comb begin
    w_push   = 1'b0;
    w_err    = 1'b0;
    w_pkt    = 1'b0;
    w_nstate = r_state;
    w_nrem   = r_rem;
    w_nfirst = r_first;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (w_kind == K_HEAD && w_par_ok && w_len != 4'd0) begin
            w_nrem = w_len;
            if (w_dst == NODE_ADDR) begin
              w_nstate = S_BODY;
              w_nfirst = 1'b1;
            end else begin
              w_nstate = S_DROP;
            end
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_BODY: begin
        if (w_acc) begin
          if (w_kind == K_BODY) begin
            w_push   = 1'b1;
            w_err    = !w_par_ok;
            w_nrem   = r_rem - 4'd1;
            w_nfirst = 1'b0;
            if (r_rem == 4'd1) begin
              w_pkt    = 1'b1;
              w_nstate = S_IDLE;
            end
          end else begin
            w_err = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (w_acc) begin
          if (w_kind == K_BODY) begin
            w_nrem = r_rem - 4'd1;
            if (r_rem == 4'd1) begin
              w_nstate = S_IDLE;
            end
          end else begin
            w_err = 1'b1;
          end
        end
      end
      default: begin
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_rem     <= '0;
      r_first   <= 1'b0;
      r_err_cnt <= '0;
      r_pkt_cnt <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_nstate;
      r_rem   <= w_nrem;
      r_first <= w_nfirst;
      if (w_err && r_err_cnt != 8'hFF) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_pkt && r_pkt_cnt != 8'hFF) begin
        r_pkt_cnt <= r_pkt_cnt + 8'd1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: validity is carried entirely by r_count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_data;
    end
  end

  assign w_head = r_mem[r_rptr];

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_valid ? w_head[7:0] : '0;
  assign out_sop   = w_out_valid ? w_head[8]   : 1'b0;
  assign out_eop   = w_out_valid ? w_head[9]   : 1'b0;
  assign out_err   = w_out_valid ? w_head[10]  : 1'b0;
  assign err_cnt   = r_err_cnt;
  assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_core_db_rx.sv
module tb_core_db_rx;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;
  logic [7:0]  pkt_cnt;

  core_db_rx #(.NODE_ADDR(4'h3), .DEPTH(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready),
    .err_cnt(err_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] v;        // {err, eop, sop, data}
    int unsigned edge_no;  // edge of acceptance; byte must show right after it
    bit          chk_lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned edge_cnt = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [1:0] K_HEAD = 2'b01;
  localparam logic [1:0] K_BODY = 2'b10;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  function automatic logic [10:0] mk(input logic [1:0] k, input logic [7:0] p, input bit bad);
    return {k, (^p) ^ bad, p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one flit; waits (bounded) for in_ready, then records the expected byte.
  task automatic send(input logic [10:0] f, input bit exp_push, input logic [2:0] flags, input bit lat);
    int unsigned n = 0;
    @(negedge CLK);
    in_data  = f;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: flit %0h not accepted within 200 cycles", f);
      in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    if (exp_push) sb.push_back('{v: {flags, f[7:0]}, edge_no: edge_cnt, chk_lat: lat});
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes still expected", sb.size());
    end
    @(negedge CLK);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT hands over a byte.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (!RESET && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h with none expected",
                   {out_err, out_eop, out_sop, out_data});
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("byte", 32'({out_err, out_eop, out_sop, out_data}), 32'(e.v));
          if (e.chk_lat) chk("latency_edge", edge_cnt, e.edge_no);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_bits", 32'({out_err, out_eop, out_sop, out_data}), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    @(negedge CLK);
    RESET = 1'b0;

    // Basic packet to this node, minimum latency checked
    send(mk(K_HEAD, 8'h32, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'hA5, 0), 1, 3'b001, 1);
    send(mk(K_BODY, 8'h3C, 0), 1, 3'b010, 1);
    drain();
    chk("t1_pkt_cnt", 32'(pkt_cnt), 1);
    chk("t1_err_cnt", 32'(err_cnt), 0);

    // Packet for another node is silently dropped
    send(mk(K_HEAD, 8'h53, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'hE1, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'hE2, 1), 0, 3'b000, 0);
    send(mk(K_BODY, 8'hE3, 0), 0, 3'b000, 0);
    @(negedge CLK);
    #1;
    chk("t2_no_out_valid", 32'(out_valid), 0);
    chk("t2_err_cnt", 32'(err_cnt), 0);
    send(mk(K_HEAD, 8'h31, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'h77, 0), 1, 3'b011, 1);
    drain();
    chk("t2_pkt_cnt", 32'(pkt_cnt), 2);

    // Parity error inside a len-1 packet, then a zero-length HEAD
    send(mk(K_HEAD, 8'h31, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'h11, 1), 1, 3'b111, 1);
    drain();
    chk("t3_err_cnt", 32'(err_cnt), 1);
    chk("t3_pkt_cnt", 32'(pkt_cnt), 3);
    send(mk(K_HEAD, 8'h30, 0), 0, 3'b000, 0);
    @(negedge CLK);
    #1;
    chk("t3_len0_err_cnt", 32'(err_cnt), 2);
    chk("t3_len0_in_ready", 32'(in_ready), 1);

    // Backpressure: len 6 into a 4-deep FIFO
    out_ready = 1'b0;
    send(mk(K_HEAD, 8'h36, 0), 0, 3'b000, 0);
    for (int i = 1; i <= 4; i++) begin
      send(mk(K_BODY, 8'(i), 0), 1, (i == 1) ? 3'b001 : 3'b000, 0);
    end
    @(negedge CLK);
    #1;
    chk("t4_full_in_ready", 32'(in_ready), 0);
    chk("t4_full_out_valid", 32'(out_valid), 1);
    fork
      begin
        send(mk(K_BODY, 8'h05, 0), 1, 3'b000, 0);
        send(mk(K_BODY, 8'h06, 0), 1, 3'b010, 0);
      end
      begin
        repeat (3) @(negedge CLK);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_pkt_cnt", 32'(pkt_cnt), 4);
    chk("t4_err_cnt", 32'(err_cnt), 2);

    // Stray BODY in IDLE, stray HEAD mid-packet
    send(mk(K_BODY, 8'h44, 0), 0, 3'b000, 0);
    send(mk(K_HEAD, 8'h32, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'h55, 0), 1, 3'b001, 1);
    send(mk(K_HEAD, 8'h31, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'h66, 0), 1, 3'b010, 1);
    drain();
    chk("t5_err_cnt", 32'(err_cnt), 4);
    chk("t5_pkt_cnt", 32'(pkt_cnt), 5);

    // Reset mid-packet with bytes sitting in the FIFO
    out_ready = 1'b0;
    send(mk(K_HEAD, 8'h34, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'hB1, 0), 1, 3'b001, 0);
    send(mk(K_BODY, 8'hB2, 0), 1, 3'b000, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    #1;
    chk("t6_rst_in_ready", 32'(in_ready), 0);
    chk("t6_rst_out_valid", 32'(out_valid), 0);
    chk("t6_rst_out_bits", 32'({out_err, out_eop, out_sop, out_data}), 0);
    chk("t6_rst_err_cnt", 32'(err_cnt), 0);
    chk("t6_rst_pkt_cnt", 32'(pkt_cnt), 0);
    sb.delete();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("t6_fifo_empty", 32'(out_valid), 0);
    out_ready = 1'b1;
    send(mk(K_HEAD, 8'h31, 0), 0, 3'b000, 0);
    send(mk(K_BODY, 8'h9A, 0), 1, 3'b011, 1);
    drain();
    chk("t6_pkt_cnt", 32'(pkt_cnt), 1);
    chk("t6_err_cnt", 32'(err_cnt), 0);

    // err_cnt saturation
    for (int i = 0; i < 300; i++) begin
      send(mk(K_BODY, 8'(i), 0), 0, 3'b000, 0);
    end
    @(negedge CLK);
    #1;
    chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
    chk("sat_pkt_cnt", 32'(pkt_cnt), 1);
    chk("sat_out_valid", 32'(out_valid), 0);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
